// File: rtl/playfield_pkg.sv
// Shared types, colours, default raster timing and small helper functions
// for the playfield controller.
package playfield_pkg;

    // Game flow states; 2'b11 is unused and recovers to PLAY at the next eof.
    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        CLEAR   = 2'd1,
        RESPAWN = 2'd2
    } state_e;

    // Widest block bus the helper functions and colour table support.
    localparam int MAX_BLK = 16;

    // Default 640x480 raster timing.
    localparam int H_ACTIVE_DEF     = 640;
    localparam int V_ACTIVE_DEF     = 480;
    localparam int H_LAST_DEF       = 799;
    localparam int V_LAST_DEF       = 524;
    localparam int CLEAR_FRAMES_DEF = 60;
    localparam int SCORE_W_DEF      = 14;

    // Object colours, {r,g,b} 4 bits each.
    localparam logic [11:0] BALL_C  = 12'hFFF;
    localparam logic [11:0] PAD_C   = 12'h0CF;
    localparam logic [11:0] WALL_C  = 12'h888;
    localparam logic [11:0] BG_C    = 12'h112;
    localparam logic [11:0] FLASH_C = 12'h532;

    // One colour per block index.
    localparam logic [11:0] BLK_C [MAX_BLK] = '{
        12'hF00, 12'hF80, 12'hFF0, 12'h8F0,
        12'h0F0, 12'h0F8, 12'h08F, 12'h00F,
        12'h80F, 12'hF0F, 12'hF08, 12'hA40,
        12'h4A0, 12'h04A, 12'h666, 12'hCCC
    };

    // Number of set bits in a block vector.
    function automatic logic [4:0] popcount(input logic [MAX_BLK-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < MAX_BLK; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [3:0] lowest_set(input logic [MAX_BLK-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = MAX_BLK - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/playfield_ctrl_frame_strobe.sv
// End-of-frame decode and the once-per-frame move / unbreak strobes.
// Strobes are updated only on pixpulse, so each one stays high from the
// clock after eof up to and including the next pixpulse: consumers that
// qualify with pixpulse see exactly one pulse, at pixel (0,0).
module frame_strobe
    import playfield_pkg::*;
#(
    parameter int H_LAST = H_LAST_DEF,
    parameter int V_LAST = V_LAST_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixpulse,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  state_e     state,
    output logic       eof,
    output logic       move,
    output logic       unbreak
);

    logic move_q, move_d;
    logic unbreak_q, unbreak_d;

    assign eof = pixpulse && (hcount == 10'(H_LAST)) && (vcount == 10'(V_LAST));

    // Next strobe values: sampled against the state in force at eof.
    always_comb begin
        move_d    = move_q;
        unbreak_d = unbreak_q;
        if (pixpulse) begin
            move_d    = eof && (state == PLAY);
            unbreak_d = eof && (state == RESPAWN);
        end
    end

    // Strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            move_q    <= 1'b0;
            unbreak_q <= 1'b0;
        end else begin
            move_q    <= move_d;
            unbreak_q <= unbreak_d;
        end
    end

    assign move    = move_q;
    assign unbreak = unbreak_q;

endmodule

// File: rtl/playfield_ctrl.sv
// Playfield arbiter: merges object draw flags into the shared empty signal,
// sequences play / clear / respawn, keeps score and level, and produces the
// registered pixel colour.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   PLAY    | normal play, move issued every frame
//   CLEAR   | all blocks broken, background flashes for CLEAR_FRAMES
//   RESPAWN | one frame boundary left; unbreak issued, move withheld
module playfield_ctrl
    import playfield_pkg::*;
#(
    parameter int NBLK         = 8,
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int H_LAST       = H_LAST_DEF,
    parameter int V_LAST       = V_LAST_DEF,
    parameter int CLEAR_FRAMES = CLEAR_FRAMES_DEF,
    parameter int SCORE_W      = SCORE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pixpulse,
    input  logic [9:0]         hcount,
    input  logic [9:0]         vcount,
    input  logic               draw_ball,
    input  logic               draw_paddle,
    input  logic               draw_walls,
    input  logic [NBLK-1:0]    draw_block,
    input  logic [NBLK-1:0]    broken,
    output logic               empty,
    output logic               move,
    output logic               unbreak,
    output logic [11:0]        rgb,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         level,
    output logic [1:0]         state_o
);

    // Extra headroom so score plus a full burst never wraps before the clamp.
    localparam int SUM_W = SCORE_W + 6;
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    state_e              state_q, state_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic [3:0]          level_q, level_d;
    logic [NBLK-1:0]     broken_q, broken_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [11:0]         rgb_q, rgb_d;

    logic                eof;
    logic [NBLK-1:0]     newly;
    logic [4:0]          new_cnt;
    logic [SUM_W-1:0]    score_sum;
    logic                in_active;

    // Neighbour sampling needs this in the same cycle as hcount/vcount.
    assign empty = ~(draw_ball | draw_paddle | draw_walls | (|draw_block));

    frame_strobe #(
        .H_LAST (H_LAST),
        .V_LAST (V_LAST)
    ) u_frame_strobe (
        .clk      (clk),
        .rst      (rst),
        .pixpulse (pixpulse),
        .hcount   (hcount),
        .vcount   (vcount),
        .state    (state_q),
        .eof      (eof),
        .move     (move),
        .unbreak  (unbreak)
    );

    // Game-flow next state; only an eof can move the state machine.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        level_d     = level_q;
        if (eof) begin
            case (state_q)
                PLAY: begin
                    if (&broken) begin
                        state_d     = CLEAR;
                        frame_cnt_d = '0;
                        level_d     = level_q + 4'd1;
                    end
                end
                CLEAR: begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    if (frame_cnt_q == 8'(CLEAR_FRAMES - 1)) begin
                        state_d = RESPAWN;
                    end
                end
                RESPAWN: begin
                    state_d = PLAY;
                end
                default: begin
                    state_d = PLAY;
                end
            endcase
        end
    end

    // Newly broken blocks only; blocks restored by unbreak fall 1->0 and
    // contribute nothing.
    assign newly     = broken & ~broken_q;
    assign new_cnt   = popcount(MAX_BLK'(newly));
    assign score_sum = SUM_W'(score_q) + SUM_W'(new_cnt);

    // Score and broken history, advanced once per pixel.
    always_comb begin
        broken_d = broken_q;
        score_d  = score_q;
        if (pixpulse) begin
            broken_d = broken;
            if (score_sum > SUM_W'(SCORE_MAX)) begin
                score_d = SCORE_MAX;
            end else begin
                score_d = score_sum[SCORE_W-1:0];
            end
        end
    end

    assign in_active = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));

    // Pixel colour by object priority, one pixel of latency.
    always_comb begin
        rgb_d = rgb_q;
        if (pixpulse) begin
            if (!in_active) begin
                rgb_d = '0;
            end else if (draw_ball) begin
                rgb_d = BALL_C;
            end else if (draw_paddle) begin
                rgb_d = PAD_C;
            end else if (draw_walls) begin
                rgb_d = WALL_C;
            end else if (|draw_block) begin
                rgb_d = BLK_C[lowest_set(MAX_BLK'(draw_block))];
            end else if ((state_q == CLEAR) && frame_cnt_q[3]) begin
                rgb_d = FLASH_C;
            end else begin
                rgb_d = BG_C;
            end
        end
    end

    // State machine and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PLAY;
            frame_cnt_q <= '0;
            level_q     <= '0;
            broken_q    <= '0;
            score_q     <= '0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            level_q     <= level_d;
            broken_q    <= broken_d;
            score_q     <= score_d;
            rgb_q       <= rgb_d;
        end
    end

    assign rgb     = rgb_q;
    assign score   = score_q;
    assign level   = level_q;
    assign state_o = state_q;

endmodule
